// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: state codes, opcodes,
// ALU operation codes, mux selects and the decoded control word.
package multicycle_controller_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_REXEC  = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BEQ    = 4'd8;
    localparam logic [3:0] S_ADDIEX = 4'd9;
    localparam logic [3:0] S_ORIEX  = 4'd10;
    localparam logic [3:0] S_IMMWB  = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;

    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_ORI   = 6'b001101;
    localparam logic [5:0] OPC_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b101;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic       branch;
        logic       pc_write;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [2:0] alu_op;
    } control_word_t;

endpackage

// File: rtl/mc_output_decode.sv
// Pure Moore decode: maps the current state to its raw control word.
// Unencoded states produce an all-zero word.
module mc_output_decode
    import multicycle_controller_pkg::*;
(
    input  logic [3:0]    state,
    output control_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_read  = 1'b1;
                cw.ir_write  = 1'b1;
                cw.pc_write  = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALU_ADD;
                cw.pc_src    = PCSRC_ALU;
            end
            // Branch target precompute while the opcode is being decoded.
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMM_SH2;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                cw.mem_read = 1'b1;
                cw.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                cw.reg_write  = 1'b1;
                cw.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_write = 1'b1;
                cw.i_or_d    = 1'b1;
            end
            S_REXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                cw.reg_write = 1'b1;
                cw.reg_dst   = 1'b1;
            end
            S_BEQ: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_REG;
                cw.alu_op    = ALU_SUB;
                cw.branch    = 1'b1;
                cw.pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
            end
            S_ORIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_OR;
            end
            S_IMMWB: begin
                cw.reg_write = 1'b1;
            end
            S_JUMP: begin
                cw.pc_write = 1'b1;
                cw.pc_src   = PCSRC_JUMP;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: state register, next-state logic and the few
// outputs that depend on inputs (fetch hold, illegal opcode, pc_en, reset gating).
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic             branch,
    output logic             pc_write,
    output logic             pc_en,
    output logic             illegal_op,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic [2:0]       alu_op,
    output logic [3:0]       state
);

    logic [3:0]    state_q;
    logic [3:0]    state_d;
    logic [3:0]    decode_target;
    logic          op_known;
    logic          fetch_hold;
    control_word_t cw;

    mc_output_decode u_output_decode (
        .state (state_q),
        .cw    (cw)
    );

    always_comb begin
        decode_target = S_FETCH;
        op_known      = 1'b1;
        case (op)
            OPC_W'(OPC_LW),
            OPC_W'(OPC_SW):    decode_target = S_MEMADR;
            OPC_W'(OPC_RTYPE): decode_target = S_REXEC;
            OPC_W'(OPC_BEQ):   decode_target = S_BEQ;
            OPC_W'(OPC_ADDI):  decode_target = S_ADDIEX;
            OPC_W'(OPC_ORI):   decode_target = S_ORIEX;
            OPC_W'(OPC_J):     decode_target = S_JUMP;
            default: begin
                decode_target = S_FETCH;
                op_known      = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = decode_target;
            S_MEMADR: state_d = (op == OPC_W'(OPC_LW)) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BEQ:    state_d = S_FETCH;
            S_ADDIEX: state_d = S_IMMWB;
            S_ORIEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // A stalled fetch must not latch IR or advance PC until memory responds.
    assign fetch_hold = (state_q == S_FETCH) && !mem_ready;

    assign ir_write   = cw.ir_write & ~fetch_hold & ~rst;
    assign pc_write   = cw.pc_write & ~fetch_hold & ~rst;
    assign mem_read   = cw.mem_read & ~rst;
    assign mem_write  = cw.mem_write & ~rst;
    assign reg_write  = cw.reg_write & ~rst;
    assign pc_en      = ~rst & (pc_write | (cw.branch & zero));
    assign illegal_op = (state_q == S_DECODE) & ~op_known & ~rst;

    assign i_or_d     = cw.i_or_d;
    assign mem_to_reg = cw.mem_to_reg;
    assign reg_dst    = cw.reg_dst;
    assign alu_src_a  = cw.alu_src_a;
    assign branch     = cw.branch;
    assign alu_src_b  = cw.alu_src_b;
    assign pc_src     = cw.pc_src;
    assign alu_op     = cw.alu_op;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Cycle-by-cycle check of state and every control output against a
// reference decode of the controller's behaviour, via an expected queue.
module tb_multicycle_controller;
    import multicycle_controller_pkg::*;

    localparam int W = 23;

    logic       clk;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_dst;
    logic       reg_write, alu_src_a, branch, pc_write, pc_en, illegal_op;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic [3:0] state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_word;
    int           checks = 0;
    int           errors = 0;
    int           cyc_idx = 0;
    string        scen = "init";

    multicycle_controller #(.OPC_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .branch     (branch),
        .pc_write   (pc_write),
        .pc_en      (pc_en),
        .illegal_op (illegal_op),
        .alu_src_b  (alu_src_b),
        .pc_src     (pc_src),
        .alu_op     (alu_op),
        .state      (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    assign got_word = {state, ir_write, i_or_d, mem_read, mem_write, mem_to_reg,
                       reg_dst, reg_write, alu_src_a, branch, pc_write, pc_en,
                       illegal_op, alu_src_b, pc_src, alu_op};

    function automatic logic [W-1:0] exp_word(input logic [3:0] st, input logic [5:0] o,
                                              input logic z, input logic mr, input logic r);
        logic       irw, iod, mrd, mwr, m2r, rd, rw, sa, br, pw, pe, ill;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {irw, iod, mrd, mwr, m2r, rd, rw, sa, br, pw, pe, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            S_FETCH:  begin mrd = ~r; irw = mr & ~r; pw = mr & ~r; sb = 2'b01; end
            S_DECODE: begin
                sb  = 2'b11;
                ill = ~r & !(o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                       6'b001000, 6'b001101, 6'b000010});
            end
            S_MEMADR: begin sa = 1'b1; sb = 2'b10; end
            S_MEMRD:  begin mrd = ~r; iod = 1'b1; end
            S_MEMWB:  begin rw = ~r; m2r = 1'b1; end
            S_MEMWR:  begin mwr = ~r; iod = 1'b1; end
            S_REXEC:  begin sa = 1'b1; ao = 3'b010; end
            S_ALUWB:  begin rw = ~r; rd = 1'b1; end
            S_BEQ:    begin sa = 1'b1; ao = 3'b001; br = 1'b1; ps = 2'b01; end
            S_ADDIEX: begin sa = 1'b1; sb = 2'b10; end
            S_ORIEX:  begin sa = 1'b1; sb = 2'b10; ao = 3'b101; end
            S_IMMWB:  begin rw = ~r; end
            S_JUMP:   begin pw = ~r; ps = 2'b10; end
            default:  ;
        endcase
        pe = ~r & (pw | (br & z));
        return {st, irw, iod, mrd, mwr, m2r, rd, rw, sa, br, pw, pe, ill, sb, ps, ao};
    endfunction

    task automatic check_word(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %06h required %06h", tag, got, exp);
        end
    endtask

    // driver: one clock cycle with given inputs and the state expected in it
    task automatic cyc(input logic [5:0] o, input logic z, input logic mr,
                       input logic r, input logic [3:0] es);
        op = o; zero = z; mem_ready = mr; rst = r;
        exp_q.push_back(exp_word(es, o, z, mr, r));
        @(negedge clk);
        check_word($sformatf("%s_c%0d", scen, cyc_idx), got_word, exp_q.pop_front());
        cyc_idx++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_instr(input string name, input logic [5:0] o, input logic z,
                             input int fetch_waits, input int mem_waits);
        scen = name;
        cyc_idx = 0;
        for (int i = 0; i < fetch_waits; i++) cyc(o, z, 1'b0, 1'b0, S_FETCH);
        cyc(o, z, 1'b1, 1'b0, S_FETCH);
        cyc(o, z, rb(), 1'b0, S_DECODE);
        case (o)
            OPC_LW: begin
                cyc(o, z, rb(), 1'b0, S_MEMADR);
                for (int i = 0; i < mem_waits; i++) cyc(o, z, 1'b0, 1'b0, S_MEMRD);
                cyc(o, z, 1'b1, 1'b0, S_MEMRD);
                cyc(o, z, rb(), 1'b0, S_MEMWB);
            end
            OPC_SW: begin
                cyc(o, z, rb(), 1'b0, S_MEMADR);
                for (int i = 0; i < mem_waits; i++) cyc(o, z, 1'b0, 1'b0, S_MEMWR);
                cyc(o, z, 1'b1, 1'b0, S_MEMWR);
            end
            OPC_RTYPE: begin
                cyc(o, z, rb(), 1'b0, S_REXEC);
                cyc(o, z, rb(), 1'b0, S_ALUWB);
            end
            OPC_BEQ:  cyc(o, z, rb(), 1'b0, S_BEQ);
            OPC_ADDI: begin
                cyc(o, z, rb(), 1'b0, S_ADDIEX);
                cyc(o, z, rb(), 1'b0, S_IMMWB);
            end
            OPC_ORI: begin
                cyc(o, z, rb(), 1'b0, S_ORIEX);
                cyc(o, z, rb(), 1'b0, S_IMMWB);
            end
            OPC_J:    cyc(o, z, rb(), 1'b0, S_JUMP);
            default:  ;
        endcase
    endtask

    initial begin
        logic [5:0] ops [8];
        ops = '{OPC_LW, OPC_SW, OPC_RTYPE, OPC_BEQ, OPC_ADDI, OPC_ORI, OPC_J, 6'b111111};

        rst = 1'b1; op = '0; zero = 1'b0; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        scen = "reset";
        cyc(6'd0, 1'b0, rb(), 1'b1, S_FETCH);
        cyc(6'd0, 1'b0, rb(), 1'b1, S_FETCH);

        run_instr("lw",       OPC_LW,    1'b0, 0, 0);
        run_instr("sw_wait3", OPC_SW,    1'b1, 0, 3);
        run_instr("beq_z1",   OPC_BEQ,   1'b1, 0, 0);
        run_instr("beq_z0",   OPC_BEQ,   1'b0, 0, 0);
        run_instr("illegal",  6'b111111, 1'b0, 0, 0);
        run_instr("b2b_r",    OPC_RTYPE, 1'b0, 0, 0);
        run_instr("b2b_ori",  OPC_ORI,   1'b1, 0, 0);
        run_instr("b2b_j",    OPC_J,     1'b0, 0, 0);
        run_instr("addi",     OPC_ADDI,  1'b1, 0, 0);
        run_instr("fetch_wait_r", OPC_RTYPE, 1'b0, 2, 0);

        // reset arriving while a load is stalled on memory
        scen = "rst_memrd";
        cyc_idx = 0;
        cyc(OPC_LW, 1'b0, 1'b1, 1'b0, S_FETCH);
        cyc(OPC_LW, 1'b0, 1'b1, 1'b0, S_DECODE);
        cyc(OPC_LW, 1'b0, 1'b1, 1'b0, S_MEMADR);
        cyc(OPC_LW, 1'b0, 1'b0, 1'b0, S_MEMRD);
        cyc(OPC_LW, 1'b0, 1'b0, 1'b1, S_MEMRD);
        cyc(OPC_LW, 1'b0, 1'b0, 1'b1, S_FETCH);
        run_instr("after_rst", OPC_SW, 1'b0, 0, 0);

        for (int k = 0; k < 12; k++) begin
            run_instr($sformatf("rand%0d", k), ops[$urandom_range(0, 7)], rb(),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        scen = "final";
        cyc_idx = 0;
        cyc(6'd0, 1'b0, 1'b0, 1'b0, S_FETCH);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
